// File: rtl/reg_bank_rw.sv
// 32-entry register file with two registered read ports; register 0 reads as zero, SP preset at reset.
// Optional same-cycle write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module reg_bank_rw #(
  parameter int                DATA_W   = 32,
  parameter int                SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 227,
  parameter int                RA_INDEX = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WrAck
);

  localparam int NUM_REGS = 32;

  // Both special indices must name a real, writable register.
  if (SP_INDEX < 1 || SP_INDEX >= NUM_REGS || RA_INDEX < 1 || RA_INDEX >= NUM_REGS) begin : g_bad_index
  end

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              wr_ack_q, wr_ack_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ack_d = RegWrite && (WriteReg != 5'd0);
    rd1_d    = (ReadReg1 == 5'd0) ? '0 : regs_q[ReadReg1];
    rd2_d    = (ReadReg2 == 5'd0) ? '0 : regs_q[ReadReg2];
`ifdef REGBANK_BYPASS_EN
    // wr_ack_d already excludes index 0, so forwarding never defeats the zero register.
    if (wr_ack_d && (WriteReg == ReadReg1)) rd1_d = WriteData;
    if (wr_ack_d && (WriteReg == ReadReg2)) rd2_d = WriteData;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the array is reset in full because software relies on zeroed registers and a preset SP.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
      rd1_q    <= '0;
      rd2_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      if (wr_ack_d) regs_q[WriteReg] <= WriteData;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign WrAck     = wr_ack_q;

endmodule

// File: tb/tb_reg_bank_rw.sv
// Self-checking bench for reg_bank_rw: directed plan steps followed by random traffic,
// all compared against an array-based reference of the register file behaviour.
module tb_reg_bank_rw;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        WrAck;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mregs [32];
  logic [31:0] e_rd1, e_rd2;
  logic        e_ack;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_bank_rw dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .WrAck     (WrAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rd1"}, ReadData1, e_rd1);
    check({tag, ".rd2"}, ReadData2, e_rd2);
    check({tag, ".ack"}, {31'd0, WrAck}, {31'd0, e_ack});
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset     = rst;
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
    ReadReg1  = r1;
    ReadReg2  = r2;
  endtask

  // Reference: predict what the outputs will show after the coming edge, then advance the model.
  task automatic cycle();
    bit fwd;
    if (!reset) begin
      foreach (mregs[i]) mregs[i] = (i == 29) ? 32'd227 : 32'd0;
      e_rd1 = '0;
      e_rd2 = '0;
      e_ack = 1'b0;
    end else begin
      fwd   = BYPASS && RegWrite && (WriteReg != 0);
      e_rd1 = (ReadReg1 == 0) ? 32'd0 : (fwd && WriteReg == ReadReg1) ? WriteData : mregs[ReadReg1];
      e_rd2 = (ReadReg2 == 0) ? 32'd0 : (fwd && WriteReg == ReadReg2) ? WriteData : mregs[ReadReg2];
      e_ack = RegWrite && (WriteReg != 0);
      if (e_ack) mregs[WriteReg] = WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with a write pending: the write must be lost.
    drive(1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("reset.ack", {31'd0, WrAck}, 32'd0);
      check_model("reset");
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
    cycle();
    check("reset.sp", ReadData1, 32'd227);
    check("reset.r5", ReadData2, 32'd0);
    check_model("post_reset");

    // Basic write with a single-cycle acknowledge.
    drive(1'b1, 1'b1, 5'd8, 32'h1234_5678, 5'd0, 5'd0);
    cycle();
    check("basic.ack1", {31'd0, WrAck}, 32'd1);
    drive(1'b1, 1'b0, 5'd8, 32'h0, 5'd8, 5'd0);
    cycle();
    check("basic.ack0", {31'd0, WrAck}, 32'd0);
    check("basic.rd", ReadData1, 32'h1234_5678);
    check_model("basic");

    // Writes to register 0 are dropped silently.
    drive(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    cycle();
    check("r0.ack", {31'd0, WrAck}, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle();
    check("r0.rd1", ReadData1, 32'd0);
    check("r0.rd2", ReadData2, 32'd0);
    check_model("r0");

    // Same-cycle write and read of one index.
    drive(1'b1, 1'b1, 5'd31, 32'h10, 5'd0, 5'd0);
    cycle();
    drive(1'b1, 1'b1, 5'd31, 32'h40, 5'd31, 5'd0);
    cycle();
    check("collide.rd", ReadData1, BYPASS ? 32'h40 : 32'h10);
    check_model("collide");
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    cycle();
    check("collide.next1", ReadData1, 32'h40);
    check("collide.next2", ReadData2, 32'h40);

    // Dual-port read, then a reset that swallows a concurrent write.
    drive(1'b1, 1'b1, 5'd2, 32'd7, 5'd0, 5'd0);
    cycle();
    drive(1'b1, 1'b1, 5'd3, 32'd9, 5'd0, 5'd0);
    cycle();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd2, 5'd3);
    cycle();
    check("dual.rd1", ReadData1, 32'd7);
    check("dual.rd2", ReadData2, 32'd9);
    drive(1'b0, 1'b1, 5'd2, 32'd1, 5'd2, 5'd3);
    cycle();
    check("midrst.rd1", ReadData1, 32'd0);
    check("midrst.rd2", ReadData2, 32'd0);
    check("midrst.ack", {31'd0, WrAck}, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd2, 5'd31);
    cycle();
    check("midrst.r2", ReadData1, 32'd0);
    check("midrst.r31", ReadData2, 32'd0);
    check_model("midrst");

    // Sweep: reg i = 4*i, then read pairs (i, 32-i).
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), 32'(i * 4), 5'd0, 5'd0);
      cycle();
      check("sweep.ack", {31'd0, WrAck}, 32'd1);
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i));
      cycle();
      check("sweep.rd1", ReadData1, 32'(i * 4));
      check("sweep.rd2", ReadData2, 32'((32 - i) * 4));
      if (i == 29) check("sweep.sp", ReadData1, 32'd116);
    end

    // Random traffic against the reference, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom(), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) ReadReg1 = WriteReg;
      if ($urandom_range(0, 3) == 0) ReadReg2 = ReadReg1;
      cycle();
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
